button_event_decoder: RTL and testbench

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/button_event_decoder.sv | 124 ++++++++++++
 tb/tb_button_event_decoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - press/short/long/auto-repeat event decoder for a debounced button
//
// Turns a clean, clk-synchronous button level into one-cycle event pulses.
// A single 26-bit counter times both the long-press threshold and the
// auto-repeat period. Every output is registered.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous reset, active low
//   btn_in         debounced button level, 1 = pressed
//   press_pulse    one cycle on each accepted press (rising edge of btn_in)
//   short_pulse    one cycle on release before the long-press threshold
//   long_pulse     one cycle when the hold reaches LONG_TIME cycles
//   repeat_pulse   one cycle every REPEAT_PERIOD cycles after long_pulse
//   release_pulse  one cycle on any release of an accepted press
//   held           level, high from the press_pulse cycle until release
//   repeat_count   repeat pulses issued in the current press, saturating at 255

module button_event_decoder #(
    parameter int LONG_TIME     = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       press_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       release_pulse,
    output logic       held,
    output logic [7:0] repeat_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    localparam logic [25:0] LONG_LAST   = 26'(LONG_TIME - 1);
    localparam logic [25:0] REPEAT_LAST = 26'(REPEAT_PERIOD - 1);

    state_t      state;
    logic [25:0] counter;
    logic        btn_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            counter       <= '0;
            // Resetting to 1 means a button held through reset is not seen
            // as a fresh press until it is released and pressed again.
            btn_prev      <= 1'b1;
            press_pulse   <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            held          <= 1'b0;
            repeat_count  <= '0;
        end else begin
            btn_prev      <= btn_in;
            press_pulse   <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    counter <= '0;
                    if (btn_in && !btn_prev) begin
                        state        <= PRESSED;
                        press_pulse  <= 1'b1;
                        held         <= 1'b1;
                        repeat_count <= '0;
                    end
                end

                PRESSED: begin
                    // Release is tested first so it wins over a coincident threshold.
                    if (!btn_in) begin
                        state         <= IDLE;
                        short_pulse   <= 1'b1;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        counter       <= '0;
                    end else if (counter == LONG_LAST) begin
                        state      <= LONG_HELD;
                        long_pulse <= 1'b1;
                        counter    <= '0;
                    end else begin
                        counter <= counter + 26'd1;
                    end
                end

                LONG_HELD: begin
                    if (!btn_in) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        counter       <= '0;
                    end else if (counter == REPEAT_LAST) begin
                        repeat_pulse <= 1'b1;
                        counter      <= '0;
                        if (repeat_count != 8'hFF) begin
                            repeat_count <= repeat_count + 8'd1;
                        end
                    end else begin
                        counter <= counter + 26'd1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    counter <= '0;
                    held    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - self-checking bench for button_event_decoder

module tb_button_event_decoder;

    localparam int LT = 8;
    localparam int RP = 4;

    logic       clk;
    logic       reset;
    logic       btn_in;
    logic       press_pulse;
    logic       short_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       release_pulse;
    logic       held;
    logic [7:0] repeat_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: "hold age" of the current press in edges.
    bit m_active;
    int m_age;
    bit m_prev;
    int m_rc;
    bit m_press, m_short, m_long, m_rep, m_rel, m_held;

    // Event counters used for per-scenario summaries.
    int n_press, n_short, n_long, n_rep, n_rel;

    button_event_decoder #(
        .LONG_TIME    (LT),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .press_pulse  (press_pulse),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .release_pulse(release_pulse),
        .held         (held),
        .repeat_count (repeat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_active = 0; m_age = 0; m_prev = 1; m_rc = 0;
        m_press = 0; m_short = 0; m_long = 0; m_rep = 0; m_rel = 0; m_held = 0;
    endfunction

    // Events derived from the age of the press: long at age LT, repeats at
    // every further multiple of RP; a release before age LT is short.
    function automatic void model_edge(input bit b);
        m_press = 0; m_short = 0; m_long = 0; m_rep = 0; m_rel = 0;
        if (m_active) begin
            if (b) begin
                m_age++;
                if (m_age == LT) m_long = 1;
                else if (m_age > LT && ((m_age - LT) % RP) == 0) begin
                    m_rep = 1;
                    m_rc  = (m_rc < 255) ? m_rc + 1 : 255;
                end
            end else begin
                m_rel    = 1;
                m_short  = (m_age < LT);
                m_active = 0;
                m_held   = 0;
            end
        end else if (b && !m_prev) begin
            m_press = 1; m_active = 1; m_age = 0; m_rc = 0; m_held = 1;
        end
        m_prev = b;
    endfunction

    task automatic check_all(input string where);
        chk({where, ":press"},   8'(press_pulse),   8'(m_press));
        chk({where, ":short"},   8'(short_pulse),   8'(m_short));
        chk({where, ":long"},    8'(long_pulse),    8'(m_long));
        chk({where, ":repeat"},  8'(repeat_pulse),  8'(m_rep));
        chk({where, ":release"}, 8'(release_pulse), 8'(m_rel));
        chk({where, ":held"},    8'(held),          8'(m_held));
        chk({where, ":rcount"},  repeat_count,      8'(m_rc));
    endtask

    // Called at a negedge: drive, clock, then compare at the following negedge.
    task automatic step(input bit b, input string where);
        btn_in = b;
        @(posedge clk);
        model_edge(b);
        @(negedge clk);
        check_all(where);
        n_press += int'(press_pulse);
        n_short += int'(short_pulse);
        n_long  += int'(long_pulse);
        n_rep   += int'(repeat_pulse);
        n_rel   += int'(release_pulse);
    endtask

    task automatic clear_counts();
        n_press = 0; n_short = 0; n_long = 0; n_rep = 0; n_rel = 0;
    endtask

    // Asserts reset between edges and checks the asynchronous clear.
    task automatic do_reset(input string where);
        #2 reset = 1'b0;
        model_reset();
        #1 check_all({where, ":async"});
        @(negedge clk);
        check_all({where, ":inreset"});
        reset = 1'b1;
    endtask

    initial begin
        int since_press;
        int hold;
        reset  = 1'b0;
        btn_in = 1'b0;
        model_reset();
        #1 check_all("por");
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(0, "idle");

        // Short press: 3 high cycles then release.
        clear_counts();
        for (int i = 0; i < 3; i++) step(1, "short3");
        step(0, "short3");
        step(0, "short3");
        chk("short3:n_short", 8'(n_short), 8'd1);
        chk("short3:n_long",  8'(n_long),  8'd0);

        // Long hold with repeats; long_pulse timing relative to press_pulse.
        clear_counts();
        since_press = -1;
        for (int i = 0; i < 21; i++) begin
            step(1, "hold20");
            if (press_pulse) since_press = 0;
            else if (since_press >= 0) since_press++;
            if (long_pulse) chk("hold20:long_delay", 8'(since_press), 8'(LT));
        end
        chk("hold20:rcount", repeat_count, 8'd3);
        step(0, "hold20");
        chk("hold20:n_short", 8'(n_short), 8'd0);
        chk("hold20:n_rel",   8'(n_rel),   8'd1);
        step(0, "hold20");
        chk("hold20:rc_kept", repeat_count, 8'd3);

        // Release coinciding with the long threshold.
        clear_counts();
        for (int i = 0; i < LT; i++) step(1, "edge7");
        step(0, "edge7");
        chk("edge7:n_short", 8'(n_short), 8'd1);
        chk("edge7:n_long",  8'(n_long),  8'd0);
        step(0, "edge7");

        // Button held across reset deassertion.
        btn_in = 1'b1;
        do_reset("holdrst");
        clear_counts();
        for (int i = 0; i < 10; i++) step(1, "holdrst");
        chk("holdrst:n_press", 8'(n_press), 8'd0);
        step(0, "holdrst");
        step(1, "holdrst");
        chk("holdrst:press", 8'(press_pulse), 8'd1);
        step(0, "holdrst");

        // Saturation of repeat_count.
        clear_counts();
        for (int i = 0; i < LT + RP * 300 + 6; i++) step(1, "sat");
        chk("sat:rcount", repeat_count, 8'd255);
        chk("sat:n_rep_ge300", 8'(n_rep >= 300), 8'd1);

        // Reset while in LONG_HELD aborts silently, then a normal press.
        do_reset("rst_long");
        btn_in = 1'b0;
        step(0, "after_rst");
        step(1, "after_rst");
        chk("after_rst:press", 8'(press_pulse), 8'd1);
        for (int i = 0; i < 4; i++) step(1, "after_rst");
        step(0, "after_rst");

        // Randomized presses, occasional mid-press reset.
        for (int p = 0; p < 40; p++) begin
            int gap = $urandom_range(1, 4);
            for (int i = 0; i < gap; i++) step(0, "rnd_gap");
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(LT - 1, LT + 3 * RP + 2)
                                                : $urandom_range(1, 30);
            for (int i = 0; i < hold; i++) step(1, "rnd_hold");
            if ($urandom_range(0, 9) == 0) do_reset("rnd_rst");
        end
        step(0, "tail");
        step(0, "tail");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
